spi_cmd_decoder: RTL



---
 rtl/spi_cmd_pkg.sv | 22 ++
 rtl/spi_cmd_decoder_sync_2ff.sv | 28 ++
 rtl/spi_cmd_decoder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: FSM encoding,
// command-byte field positions and the register width.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_DRAIN
    } state_e;

    localparam int CMD_WRITE_BIT = 7;
    localparam int CMD_ADDR_MSB  = 6;
    localparam int REG_W         = 16;

    // True when an 8-bit zero-extended address lies inside the register file.
    function automatic logic addr_ok(input logic [7:0] a, input int n);
        return int'(a) < n;
    endfunction

endpackage

// File: rtl/spi_cmd_decoder_sync_2ff.sv
// Reusable two-flop synchronizer for a single asynchronous level.
// RST_VAL sets the value both flops take during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops to let metastability resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// Turns framed SPI byte streams into control-register writes.
// Define SPI_CMD_AUTOINC_EN for burst writes with address auto-increment.
module spi_cmd_decoder
    import spi_cmd_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_ss,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid,
    output logic                      reg_wr_en,
    output logic [ADDR_W-1:0]         reg_wr_addr,
    output logic [REG_W-1:0]          reg_wr_data,
    output logic [NUM_REGS*REG_W-1:0] regs_flat,
    output logic                      cmd_error
);

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         hi_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [REG_W-1:0]   wr_data_q;
    logic               err_q;
    logic               ss_prev_q;
    logic [REG_W-1:0]   regs_q [NUM_REGS];

    logic               ss_sync;
    logic               ss_active;
    logic               ss_rise;
    logic               cmd_ok;
    logic               commit;
    logic [REG_W-1:0]   word;

`ifdef SPI_CMD_AUTOINC_EN
    logic [7:0]         addr_nxt;
    assign addr_nxt = 8'(addr_q) + 8'd1;
`endif

    // Chip select idles high, so the synchronizer resets to inactive.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (spi_ss),
        .q_o   (ss_sync)
    );

    assign ss_active = ~ss_sync;
    assign ss_rise   = ss_active & ~ss_prev_q;

    assign cmd_ok = byte_in[CMD_WRITE_BIT]
                  & addr_ok({1'b0, byte_in[CMD_ADDR_MSB:0]}, NUM_REGS);

    assign commit = ss_active & byte_valid & (state_q == ST_DATA_LO);
    assign word   = {hi_q, byte_in};

    // Frame FSM with registered strobe, write-echo and error outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            hi_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
            ss_prev_q <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            ss_prev_q <= ss_active;
            if (!ss_active) begin
                state_q <= ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (ss_rise) begin
                            state_q <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (byte_valid) begin
                            if (cmd_ok) begin
                                addr_q  <= ADDR_W'(byte_in[CMD_ADDR_MSB:0]);
                                state_q <= ST_DATA_HI;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_DRAIN;
                            end
                        end
                    end
                    ST_DATA_HI: begin
                        if (byte_valid) begin
                            hi_q    <= byte_in;
                            state_q <= ST_DATA_LO;
                        end
                    end
                    ST_DATA_LO: begin
                        if (byte_valid) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q;
                            wr_data_q <= word;
`ifdef SPI_CMD_AUTOINC_EN
                            addr_q    <= addr_nxt[ADDR_W-1:0];
                            if (addr_ok(addr_nxt, NUM_REGS)) begin
                                state_q <= ST_DATA_HI;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= ST_DRAIN;
                            end
`else
                            state_q   <= ST_DRAIN;
`endif
                        end
                    end
                    ST_DRAIN: begin
                        state_q <= ST_DRAIN;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Register file: one word written per committed data pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_q == ADDR_W'(i)) begin
                    regs_q[i] <= word;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[REG_W*g +: REG_W] = regs_q[g];
    end

    assign reg_wr_en   = wr_en_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign cmd_error   = err_q;

endmodule
